// File: rtl/if_stage.sv
// Instruction fetch stage: single outstanding fetch, output register plus one-entry skid.
// Redirects kill the in-flight fetch. The current state is exported on dbg_state.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [63:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [63:0] skid_pc_q, skid_pc_d;

  // Handshakes: a request transfers on a cycle with inst_req && inst_gnt; exactly one
  // inst_rvalid answers each transfer; decode takes if_inst on a cycle with if_valid && id_ready.
  assign inst_req  = (state_q == S_REQ) && !rst;
  assign inst_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_inst   = if_inst_q;
  assign if_pc     = if_pc_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_inst_d    = if_inst_q;
    if_pc_d      = if_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;

    if (if_valid_q && id_ready) if_valid_d = 1'b0;

    if (redirect) begin
      // Target is word aligned; anything buffered belongs to the wrong path.
      pc_d         = redirect_pc & ~64'h3;
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      unique case (state_q)
        S_REQ:   state_d = inst_gnt ? S_KILL : S_REQ;
        S_WAIT:  state_d = inst_rvalid ? S_REQ : S_KILL;
        S_HOLD:  state_d = S_REQ;
        S_KILL:  state_d = inst_rvalid ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (inst_gnt) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (inst_rvalid) begin
            pc_d = pc_q + 64'd4;
            if (!if_valid_q || id_ready) begin
              if_valid_d = 1'b1;
              if_inst_d  = inst_rdata;
              if_pc_d    = pc_q;
              state_d    = S_REQ;
            end else begin
              skid_valid_d = 1'b1;
              skid_inst_d  = inst_rdata;
              skid_pc_d    = pc_q;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            if_valid_d   = 1'b1;
            if_inst_d    = skid_inst_q;
            if_pc_d      = skid_pc_q;
            skid_valid_d = 1'b0;
            state_d      = S_REQ;
          end
        end
        S_KILL: begin
          if (inst_rvalid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_inst_q    <= '0;
      if_pc_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_valid_q   <= if_valid_d;
      if_inst_q    <= if_inst_d;
      if_pc_q      <= if_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 inst_req  output  1  fetch request valid to instruction memory.
REQ-005 inst_addr  output  64  fetch address; valid while inst_req=1.
REQ-006 inst_gnt  input  1  memory accepts request this cycle when inst_req=1.
REQ-007 inst_rvalid  input  1  fetch response valid, one cycle per accepted request.
REQ-008 inst_rdata  input  32  fetched instruction word.
REQ-009 id_ready  input  1  decode consumes if_inst this cycle when if_valid=1.
REQ-010 redirect  input  1  branch/jump/exception redirect request.
REQ-011 redirect_pc  input  64  redirect target.
REQ-012 if_valid  output  1  if_inst/if_pc hold a valid instruction for decode.
REQ-013 if_inst  output  32  instruction to decode.
REQ-014 if_pc  output  64  address of if_inst.

Function
REQ-015 At most one fetch SHALL be outstanding; PC register pc SHALL drive inst_addr.
REQ-016 States SHALL be REQ (request driven), WAIT (accepted, awaiting rvalid), HOLD (response parked in skid), KILL (awaiting a response to discard).
REQ-017 REQ: inst_req=1; on inst_gnt -> WAIT; inst_req SHALL be 0 in all other states.
REQ-018 inst_rvalid outside WAIT/KILL SHALL be ignored.
REQ-019 WAIT, inst_rvalid: if output register free (if_valid=0 or id_ready=1) load if_inst=inst_rdata, if_pc=pc, if_valid=1 -> REQ; else write one-entry skid (data, pc) -> HOLD; pc<=pc+4 in both cases.
REQ-020 HOLD: when id_ready=1, skid SHALL move to output register next edge, skid cleared -> REQ; no request issued in HOLD.
REQ-021 Output register: if_valid cleared on id_ready with no new load; if_inst/if_pc SHALL remain stable while if_valid=1 and id_ready=0.
REQ-022 pc+4 SHALL wrap modulo 2^64.
REQ-023 redirect SHALL have highest priority: pc<=redirect_pc with bits [1:0] forced to 0; if_valid and skid cleared on the same edge.
REQ-024 redirect in REQ without inst_gnt, or in HOLD -> REQ; redirect in REQ with inst_gnt, or in WAIT without inst_rvalid -> KILL.
REQ-025 redirect in WAIT with inst_rvalid same cycle: response discarded -> REQ.
REQ-026 KILL: next inst_rvalid SHALL be discarded (no output update, pc unchanged) -> REQ; redirect in KILL updates pc, stays KILL unless inst_rvalid same cycle (then -> REQ).
REQ-027 Best-case throughput: one instruction per two cycles with single-cycle memory; latency from inst_gnt to if_valid SHALL be response latency plus one cycle.

Reset
REQ-028 On rst=1 at a rising edge: pc=RESET_PC, state=REQ, if_valid=0, if_inst=0, if_pc=0, skid empty; rst SHALL override redirect and all inputs.
REQ-029 Reset mid-fetch SHALL abandon the outstanding request; a late inst_rvalid after reset while in REQ SHALL be ignored.
REQ-030 During rst=1, inst_req SHALL be 0.

Verification
REQ-031 Reset release, gnt=1, rvalid one cycle later, rdata=32'h00100093, id_ready=1 -> inst_addr=0x80000000, if_valid=1, if_inst=0x00100093, if_pc=0x80000000; next inst_addr=0x80000004.
REQ-032 Two fetches, id_ready=0 -> second response held in skid, state HOLD, inst_req=0; raise id_ready -> if_pc 0x80000000 then 0x80000004 on consecutive cycles, no loss or duplication.
REQ-033 redirect=1, redirect_pc=0x80001003 while in WAIT -> next rvalid discarded, next inst_addr=0x80001000, if_valid stays 0 until new response.
REQ-034 redirect and inst_rvalid same cycle in WAIT -> response dropped, next cycle inst_req=1, inst_addr=redirect target.
REQ-035 pc=0xFFFF_FFFF_FFFF_FFFC fetched -> next inst_addr=0x0.
REQ-036 rst asserted while in HOLD with if_valid=1 -> next cycle if_valid=0, inst_addr=0x80000000, state REQ.
